// File: rtl/sod_cursor_ctrl.sv
// Input stage for the 4x4 sudoku board: button sync/edge detect, cursor moves with
// auto-repeat, digit-entry pulses gated by the locked diagonal, and cursor blink.
module sod_cursor_ctrl #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter int unsigned BLINK_PERIOD = 12500000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_new_game,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_btn_zero,
  input  logic       i_btn_one,
  input  logic       i_btn_two,
  input  logic       i_btn_three,
  output logic [1:0] o_location_x,
  output logic [1:0] o_location_y,
  output logic       o_zero,
  output logic       o_one,
  output logic       o_two,
  output logic       o_three,
  output logic       o_locked_hit,
  output logic       o_cursor_blink
);

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = $clog2(RptMax);
  localparam int unsigned BlkW   = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);
  localparam logic [BlkW-1:0] BlinkLast = BlkW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  // Bit order: {three, two, one, zero, right, left, down, up}
  logic [7:0]      w_raw, r_s1, r_s2, r_prev, w_press;
  logic [3:0]      w_dir_s2, w_digit_sel, r_digit;
  logic            w_digit_any, w_locked, r_locked_hit;
  state_e          r_state, w_state_d;
  logic [1:0]      r_dir, w_dir_d, w_new_dir, w_move_dir;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_move, w_move_ok;
  logic [1:0]      r_loc_x, r_loc_y, w_loc_x_d, w_loc_y_d;
  logic [BlkW-1:0] r_bcnt, w_bcnt_d;
  logic            r_blink, w_blink_d;

  assign w_raw = {i_btn_three, i_btn_two, i_btn_one, i_btn_zero, i_right, i_left, i_down, i_up};
  assign w_press     = r_s2 & ~r_prev;
  assign w_dir_s2    = r_s2[3:0];
  assign w_digit_any = |w_press[7:4];
  assign w_locked    = (r_loc_x == r_loc_y);
  assign w_move_ok   = w_move & ~w_digit_any;

  always_comb begin
    w_digit_sel = 4'b0000;
    if (w_press[4])      w_digit_sel = 4'b0001;
    else if (w_press[5]) w_digit_sel = 4'b0010;
    else if (w_press[6]) w_digit_sel = 4'b0100;
    else if (w_press[7]) w_digit_sel = 4'b1000;
  end

  always_comb begin
    w_new_dir = 2'd3;
    if (w_press[0])      w_new_dir = 2'd0;
    else if (w_press[1]) w_new_dir = 2'd1;
    else if (w_press[2]) w_new_dir = 2'd2;
  end

  // Repeat FSM keeps timing even when a digit press suppresses the move.
  always_comb begin
    w_state_d  = r_state;
    w_dir_d    = r_dir;
    w_cnt_d    = r_cnt;
    w_move     = 1'b0;
    w_move_dir = r_dir;
    unique case (r_state)
      StIdle: begin
        if (|w_press[3:0]) begin
          w_state_d  = StDelay;
          w_dir_d    = w_new_dir;
          w_move_dir = w_new_dir;
          w_cnt_d    = '0;
          w_move     = 1'b1;
        end
      end
      StDelay, StRepeat: begin
        if (!w_dir_s2[r_dir]) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt == ((r_state == StDelay) ? DelayLast : RateLast)) begin
          w_state_d = StRepeat;
          w_cnt_d   = '0;
          w_move    = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    w_loc_x_d = r_loc_x;
    w_loc_y_d = r_loc_y;
    if (w_move_ok) begin
      case (w_move_dir)
        2'd0:    w_loc_y_d = r_loc_y - 2'd1;
        2'd1:    w_loc_y_d = r_loc_y + 2'd1;
        2'd2:    w_loc_x_d = r_loc_x - 2'd1;
        default: w_loc_x_d = r_loc_x + 2'd1;
      endcase
    end
  end

  always_comb begin
    w_blink_d = r_blink;
    w_bcnt_d  = r_bcnt + BlkW'(1);
    if (w_move_ok) begin
      w_blink_d = 1'b1;
      w_bcnt_d  = '0;
    end else if (r_bcnt == BlinkLast) begin
      w_blink_d = ~r_blink;
      w_bcnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_prev       <= '0;
      r_state      <= StIdle;
      r_dir        <= 2'd0;
      r_cnt        <= '0;
      r_loc_x      <= 2'd1;
      r_loc_y      <= 2'd0;
      r_digit      <= '0;
      r_locked_hit <= 1'b0;
      r_bcnt       <= '0;
      r_blink      <= 1'b1;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      // Loading prev from s2 on newGame too means a held button yields no edge.
      r_prev <= r_s2;
      if (i_new_game) begin
        r_state      <= StIdle;
        r_dir        <= 2'd0;
        r_cnt        <= '0;
        r_loc_x      <= 2'd1;
        r_loc_y      <= 2'd0;
        r_digit      <= '0;
        r_locked_hit <= 1'b0;
        r_bcnt       <= '0;
        r_blink      <= 1'b1;
      end else begin
        r_state      <= w_state_d;
        r_dir        <= w_dir_d;
        r_cnt        <= w_cnt_d;
        r_loc_x      <= w_loc_x_d;
        r_loc_y      <= w_loc_y_d;
        r_digit      <= w_locked ? 4'b0000 : w_digit_sel;
        r_locked_hit <= w_digit_any & w_locked;
        r_bcnt       <= w_bcnt_d;
        r_blink      <= w_blink_d;
      end
    end
  end

  assign o_location_x   = r_loc_x;
  assign o_location_y   = r_loc_y;
  assign o_zero         = r_digit[0];
  assign o_one          = r_digit[1];
  assign o_two          = r_digit[2];
  assign o_three        = r_digit[3];
  assign o_locked_hit   = r_locked_hit;
  assign o_cursor_blink = r_blink;

endmodule

// File: tb/tb_sod_cursor_ctrl.sv
// Bench for sod_cursor_ctrl: directed vector table, corner-case sequences and random
// stimulus checked every cycle against a timeline-based reference model.
module tb_sod_cursor_ctrl;

  localparam int D  = 4;
  localparam int R  = 2;
  localparam int BP = 3;

  logic       clk = 1'b0;
  logic       rst, ng;
  logic [7:0] btn;  // {three, two, one, zero, right, left, down, up}
  logic [1:0] loc_x, loc_y;
  logic       p_zero, p_one, p_two, p_three, locked_hit, blink;

  always #5 clk = ~clk;

  sod_cursor_ctrl #(
    .REPEAT_DELAY(D),
    .REPEAT_RATE (R),
    .BLINK_PERIOD(BP)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_new_game    (ng),
    .i_up          (btn[0]),
    .i_down        (btn[1]),
    .i_left        (btn[2]),
    .i_right       (btn[3]),
    .i_btn_zero    (btn[4]),
    .i_btn_one     (btn[5]),
    .i_btn_two     (btn[6]),
    .i_btn_three   (btn[7]),
    .o_location_x  (loc_x),
    .o_location_y  (loc_y),
    .o_zero        (p_zero),
    .o_one         (p_one),
    .o_two         (p_two),
    .o_three       (p_three),
    .o_locked_hit  (locked_hit),
    .o_cursor_blink(blink)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: raw history for the 2-cycle sync, held-time based repeat, and
  // blink derived from cycles since the last cursor event.
  logic [7:0] m_h1, m_h2, m_prev;
  logic [1:0] m_x, m_y;
  logic [4:0] m_pulse;  // {locked, three, two, one, zero}
  logic       m_blink;
  int         m_held, m_age, m_bage;

  task automatic model_edge(input logic r, input logic n, input logic [7:0] raw);
    logic [7:0] press;
    int         mv;
    bit         dig;
    if (r) begin
      m_h1 = '0; m_h2 = '0; m_prev = '0;
      m_x = 2'd1; m_y = 2'd0; m_pulse = '0;
      m_held = -1; m_age = 0; m_bage = 0;
    end else if (n) begin
      m_x = 2'd1; m_y = 2'd0; m_pulse = '0;
      m_held = -1; m_age = 0; m_bage = 0;
      m_prev = m_h2; m_h2 = m_h1; m_h1 = raw;
    end else begin
      press   = m_h2 & ~m_prev;
      m_pulse = '0;
      dig     = |press[7:4];
      mv      = -1;
      for (int i = 4; i < 8; i++) begin
        if (press[i]) begin
          if (m_x == m_y) m_pulse[4] = 1'b1;
          else m_pulse[i-4] = 1'b1;
          break;
        end
      end
      if (m_held < 0) begin
        for (int d = 0; d < 4; d++) begin
          if (press[d]) begin
            m_held = d; m_age = 0; mv = d;
            break;
          end
        end
      end else if (!m_h2[m_held]) begin
        m_held = -1;
      end else begin
        m_age++;
        if (m_age >= D && (m_age - D) % R == 0) mv = m_held;
      end
      if (mv >= 0 && !dig) begin
        case (mv)
          0:       m_y = m_y - 2'd1;
          1:       m_y = m_y + 2'd1;
          2:       m_x = m_x - 2'd1;
          default: m_x = m_x + 2'd1;
        endcase
        m_bage = 0;
      end else begin
        m_bage++;
      end
      m_prev = m_h2; m_h2 = m_h1; m_h1 = raw;
    end
    m_blink = ((m_bage / BP) % 2) == 0;
  endtask

  function automatic logic [9:0] dut_vec();
    return {loc_x, loc_y, locked_hit, p_three, p_two, p_one, p_zero, blink};
  endfunction

  function automatic logic [9:0] mk(input int x, input int y, input logic [4:0] p,
                                    input logic b);
    logic [1:0] xx, yy;
    xx = 2'(x);
    yy = 2'(y);
    return {xx, yy, p, b};
  endfunction

  // Called at a negedge: drive, let one posedge happen, compare at the next negedge.
  task automatic step(input logic r, input logic n, input logic [7:0] b);
    rst = r; ng = n; btn = b;
    @(posedge clk);
    model_edge(r, n, b);
    @(negedge clk);
    chk("model", {6'd0, dut_vec()}, {6'd0, mk(int'(m_x), int'(m_y), m_pulse, m_blink)});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic tap(input logic [7:0] b);
    step(1'b0, 1'b0, b);
    idle(3);
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[16];
  logic [1:0] seen[$];
  logic [1:0] last_x;
  logic [7:0] rb;
  int         zcnt;

  initial begin
    tbl[0]  = '{8'h00, mk(1, 0, 5'b00000, 1'b1)};
    tbl[1]  = '{8'h00, mk(1, 0, 5'b00000, 1'b1)};
    tbl[2]  = '{8'h00, mk(1, 0, 5'b00000, 1'b0)};
    tbl[3]  = '{8'h40, mk(1, 0, 5'b00000, 1'b0)};
    tbl[4]  = '{8'h40, mk(1, 0, 5'b00000, 1'b0)};
    tbl[5]  = '{8'h40, mk(1, 0, 5'b00100, 1'b1)};
    tbl[6]  = '{8'h40, mk(1, 0, 5'b00000, 1'b1)};
    tbl[7]  = '{8'h40, mk(1, 0, 5'b00000, 1'b1)};
    tbl[8]  = '{8'h00, mk(1, 0, 5'b00000, 1'b0)};
    tbl[9]  = '{8'h02, mk(1, 0, 5'b00000, 1'b0)};
    tbl[10] = '{8'h00, mk(1, 0, 5'b00000, 1'b0)};
    tbl[11] = '{8'h00, mk(1, 1, 5'b00000, 1'b1)};
    tbl[12] = '{8'h20, mk(1, 1, 5'b00000, 1'b1)};
    tbl[13] = '{8'h00, mk(1, 1, 5'b00000, 1'b1)};
    tbl[14] = '{8'h00, mk(1, 1, 5'b10000, 1'b0)};
    tbl[15] = '{8'h00, mk(1, 1, 5'b00000, 1'b0)};

    rst = 1'b1; ng = 1'b0; btn = '0;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    chk("reset_state", {6'd0, dut_vec()}, {6'd0, mk(1, 0, 5'b00000, 1'b1)});

    // Blink cadence, digit pulse latency, locked-cell hit.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, tbl[i].btn);
      chk($sformatf("tbl%0d", i), {6'd0, dut_vec()}, {6'd0, tbl[i].exp});
    end

    // Wrap on right from X=3, wrap on up from Y=0.
    step(1'b0, 1'b1, 8'h00);
    tap(8'h02); tap(8'h02); tap(8'h08); tap(8'h08);
    chk("to_3_2", {12'd0, loc_x, loc_y}, 16'h000E);
    tap(8'h08);
    chk("right_wrap", {12'd0, loc_x, loc_y}, 16'h0002);
    step(1'b0, 1'b1, 8'h00);
    tap(8'h01);
    chk("up_wrap", {12'd0, loc_x, loc_y}, 16'h0007);

    // Held right: delay then repeat, then release.
    step(1'b0, 1'b1, 8'h00);
    tap(8'h04);
    chk("left_to_0", {14'd0, loc_x}, 16'd0);
    seen.delete();
    last_x = loc_x;
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 1'b0, (i < 12) ? 8'h08 : 8'h00);
      if (loc_x != last_x) seen.push_back(loc_x);
      last_x = loc_x;
    end
    chk("hold_moves", 16'(seen.size()), 16'd5);
    if (seen.size() == 5) begin
      chk("hold_x0", {14'd0, seen[0]}, 16'd1);
      chk("hold_x1", {14'd0, seen[1]}, 16'd2);
      chk("hold_x2", {14'd0, seen[2]}, 16'd3);
      chk("hold_x3", {14'd0, seen[3]}, 16'd0);
      chk("hold_x4", {14'd0, seen[4]}, 16'd1);
    end

    // Digit press suppresses a simultaneous move; up beats left.
    step(1'b0, 1'b1, 8'h00);
    tap(8'h08);
    zcnt = 0;
    step(1'b0, 1'b0, 8'h18);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (p_zero) zcnt++;
    end
    chk("zero_once", 16'(zcnt), 16'd1);
    chk("digit_no_move", {12'd0, loc_x, loc_y}, 16'h0008);
    tap(8'h05);
    chk("up_over_left", {12'd0, loc_x, loc_y}, 16'h000B);

    // newGame in the middle of REPEAT with right still held.
    step(1'b0, 1'b1, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'h08);
    step(1'b0, 1'b1, 8'h08);
    chk("ng_loc", {12'd0, loc_x, loc_y}, 16'h0004);
    repeat (6) step(1'b0, 1'b0, 8'h08);
    chk("ng_held_no_move", {14'd0, loc_x}, 16'd1);
    idle(3);
    tap(8'h08);
    chk("ng_repress", {14'd0, loc_x}, 16'd2);

    // Random button activity with occasional newGame/reset.
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, (b < 4) ? 7 : 11) == 0) rb[b] = ~rb[b];
      end
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0), rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
